// File: rtl/sys_counter_unit.sv
// System counter unit: cycle/time/instret counters with a small request FSM
// that returns a counter half or raises an environment trap.
//
// state | meaning
// IDLE  | ready for a request from the execute stage
// RESP  | captured counter half presented until writeback consumes it
// TRAP  | SCALL/SBREAK pending until the trap handler acknowledges it
module sys_counter_unit #(
    parameter int DATA_SIZE = 32,
    parameter int TIME_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [2:0]           sysop_i,
    output logic                 ready_o,
    input  logic                 retire_i,
    output logic [DATA_SIZE-1:0] result_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 trap_o,
    output logic                 trap_cause_o,
    input  logic                 trap_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TIME_DIV - 1);

    state_t               state_q;
    state_t               state_d;
    logic [63:0]          cycle_q;
    logic [63:0]          time_q;
    logic [63:0]          instret_q;
    logic [7:0]           presc_q;
    logic [63:0]          read_sel;
    logic [31:0]          read_word;
    logic [DATA_SIZE-1:0] result_q;
    logic                 cause_q;
    logic                 accept;
    logic                 is_trap_op;

    assign accept     = valid_i && (state_q == IDLE);
    assign is_trap_op = (sysop_i[2:1] == 2'b11);

    // Free-running counters; instret counts retirements regardless of FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            time_q    <= '0;
            instret_q <= '0;
            presc_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                time_q  <= time_q + 64'd1;
            end else begin
                presc_q <= presc_q + 8'd1;
            end
            if (retire_i) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // Select counter by op pair, then the half by the odd/even code bit
    always_comb begin
        read_sel = cycle_q;
        case (sysop_i[2:1])
            2'b01:   read_sel = time_q;
            2'b10:   read_sel = instret_q;
            default: read_sel = cycle_q;
        endcase
        read_word = sysop_i[0] ? read_sel[63:32] : read_sel[31:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = is_trap_op ? TRAP : RESP;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            TRAP: begin
                if (trap_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture pre-increment counter half or trap cause at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cause_q  <= 1'b0;
        end else if (accept) begin
            if (is_trap_op) begin
                cause_q <= sysop_i[0];
            end else begin
                result_q <= DATA_SIZE'(read_word);
            end
        end
    end

    // Outputs are gated by state so result/cause read as zero when not valid
    assign ready_o        = (state_q == IDLE);
    assign result_valid_o = (state_q == RESP);
    assign result_o       = result_valid_o ? result_q : '0;
    assign trap_o         = (state_q == TRAP);
    assign trap_cause_o   = trap_o & cause_q;

endmodule

// File: doc/sys_counter_unit.md
SYS_COUNTER_UNIT -- requirements
Module: sys_counter_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, result width.
REQ-002 SHALL have parameter TIME_DIV, default 4, clock cycles per time tick, legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  execute stage presents a system op.
REQ-006 SHALL have port sysop_i  input  3  t_sysop code: 000 RDCYCLE, 001 RDCYCLEH, 010 RDTIME, 011 RDTIMEH, 100 RDINSTRET, 101 RDINSTRETH, 110 SCALL, 111 SBREAK.
REQ-007 SHALL have port ready_o  output  1  unit can accept a request this cycle.
REQ-008 SHALL have port retire_i  input  1  one instruction retired this cycle.
REQ-009 SHALL have port result_o  output  DATA_SIZE  counter read data.
REQ-010 SHALL have port result_valid_o  output  1  result_o is valid.
REQ-011 SHALL have port result_ready_i  input  1  writeback consumes result.
REQ-012 SHALL have port trap_o  output  1  environment trap pending.
REQ-013 SHALL have port trap_cause_o  output  1  0 = SCALL, 1 = SBREAK.
REQ-014 SHALL have port trap_ack_i  input  1  trap handler has taken the trap.

Function
REQ-015 SHALL hold three 64-bit counters: cycle, time, instret.
REQ-016 cycle SHALL increment by 1 every cycle rst is low.
REQ-017 time SHALL increment by 1 when an internal prescaler reaches TIME_DIV-1; prescaler then returns to 0, otherwise increments.
REQ-018 instret SHALL increment by 1 in each cycle retire_i is high, independent of FSM state.
REQ-019 all counters SHALL wrap from 2^64-1 to 0 with no flag.
REQ-020 FSM SHALL have states IDLE, RESP, TRAP; ready_o SHALL be 1 only in IDLE.
REQ-021 request SHALL be accepted in the cycle valid_i and ready_o are both 1; valid_i with ready_o low SHALL be ignored.
REQ-022 on accepted read op (000..101), SHALL capture the selected 32-bit half (low for even codes, high [63:32] for odd codes) of the counter value present in the acceptance cycle (pre-increment) into result_o and enter RESP.
REQ-023 in RESP result_valid_o SHALL be 1 and result_o stable; read latency SHALL be exactly 1 cycle from acceptance to result_valid_o.
REQ-024 RESP SHALL return to IDLE in the cycle after result_valid_o and result_ready_i are both 1; result_valid_o SHALL clear that same edge.
REQ-025 on accepted SCALL/SBREAK, SHALL enter TRAP, set trap_o 1 and trap_cause_o per REQ-013 the next cycle; no result SHALL be produced.
REQ-026 TRAP SHALL hold trap_o and trap_cause_o until trap_ack_i is 1, then return to IDLE next cycle with trap_o 0.
REQ-027 trap_ack_i outside TRAP and result_ready_i outside RESP SHALL be ignored.
REQ-028 result_o SHALL be 0 whenever result_valid_o is 0; trap_cause_o SHALL be 0 whenever trap_o is 0.

Reset
REQ-029 rst high at a clock edge SHALL force state IDLE, all counters and prescaler 0, result_o 0, result_valid_o 0, trap_o 0, trap_cause_o 0, in any state.
REQ-030 a request, retire_i, or trap_ack_i coincident with rst SHALL be discarded; ready_o SHALL be 1 the cycle after rst falls.
REQ-031 reset mid-RESP or mid-TRAP SHALL drop the pending result or trap without completion.

Verification
REQ-032 rst then 10 idle cycles, RDCYCLE accepted on cycle 10 -> result_o = 10 with result_valid_o 1 on cycle 11.
REQ-033 TIME_DIV=4, 17 cycles after reset, RDTIME -> result_o = 4; retire_i high 5 cycles then RDINSTRET -> 5.
REQ-034 force cycle to 0x0000_0000_FFFF_FFFF, RDCYCLEH then RDCYCLE -> 0x1 high, low small value; force 0xFFFF_FFFF_FFFF_FFFF -> next cycle 0.
REQ-035 RDCYCLE with result_ready_i low 3 cycles -> result_valid_o and result_o stable 3 cycles, ready_o 0, valid_i ignored; retire_i still counted.
REQ-036 SBREAK -> trap_o 1, trap_cause_o 1 until trap_ack_i; ack at cycle N -> trap_o 0 and ready_o 1 at N+1; SCALL -> cause 0.
REQ-037 rst asserted in TRAP and in RESP -> trap_o 0, result_valid_o 0, counters 0 next cycle.
